// File: rtl/special_item_spawner.sv
// rtl/special_item_spawner.sv - picks wall-free cells for the plus/minus items, hands them to the drawer, tracks pickups
module special_item_spawner #(
  parameter int          GRID_W         = 24,
  parameter int          GRID_H         = 24,
  parameter int          RESPAWN_FRAMES = 600,
  parameter int          MAX_TRIES      = 32,
  parameter logic [15:0] LFSR_SEED      = 16'hACE1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       frame_tick,
  input  logic [4:0] player_x,
  input  logic [4:0] player_y,
  output logic [9:0] maze_addr,
  input  logic       maze_wall,
  output logic [4:0] x_plus,
  output logic [4:0] y_plus,
  output logic [4:0] x_minus,
  output logic [4:0] y_minus,
  output logic       plus_active,
  output logic       minus_active,
  output logic       draw_special,
  input  logic       draw_done,
  output logic       bonus_pulse,
  output logic       penalty_pulse
);

  localparam int TCW = $clog2(MAX_TRIES + 1);
  localparam int TMW = $clog2(RESPAWN_FRAMES + 1);
  localparam logic [TCW-1:0] TRY_LAST = TCW'(MAX_TRIES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_PICK, S_WAIT, S_CHECK, S_BACKOFF, S_DRAW, S_ARMED
  } state_t;

  state_t         state, state_nxt;
  logic [15:0]    lfsr;
  logic [TCW-1:0] try_cnt;
  logic [TMW-1:0] timer;
  logic           pend_m;
  logic [4:0]     cand_x, cand_y;
  logic [4:0]     cx, cy;
  logic           in_range, accept, reject, last_try, take_plus, take_minus;

  assign cx        = lfsr[4:0];
  assign cy        = lfsr[9:5];
  assign in_range  = (int'(cx) < GRID_W) && (int'(cy) < GRID_H);
  // pend_m means the plus cell is already chosen, so the minus must avoid it
  assign accept    = !maze_wall
                   && !(cand_x == player_x && cand_y == player_y)
                   && !(pend_m && cand_x == x_plus && cand_y == y_plus);
  assign reject    = (state == S_PICK && !in_range) || (state == S_CHECK && !accept);
  assign last_try  = (try_cnt == TRY_LAST);
  assign take_plus  = enable && state == S_ARMED && plus_active
                    && player_x == x_plus && player_y == y_plus;
  assign take_minus = enable && state == S_ARMED && minus_active
                    && player_x == x_minus && player_y == y_minus;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) lfsr <= LFSR_SEED;
    else       lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    state_nxt = S_PICK;
      S_PICK:    if (in_range)      state_nxt = S_WAIT;
                 else if (last_try) state_nxt = S_BACKOFF;
      S_WAIT:    state_nxt = S_CHECK;
      S_CHECK:   if (accept)        state_nxt = pend_m ? S_DRAW : S_PICK;
                 else if (last_try) state_nxt = S_BACKOFF;
                 else               state_nxt = S_PICK;
      S_BACKOFF: if (frame_tick)    state_nxt = S_PICK;
      S_DRAW:    if (draw_done)     state_nxt = S_ARMED;
      S_ARMED:   if ((!plus_active && !minus_active) || timer == '0) state_nxt = S_PICK;
      default:   state_nxt = S_IDLE;
    endcase
    if (!enable) state_nxt = S_IDLE;
  end

  always_comb begin
    draw_special = (state == S_DRAW);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      maze_addr     <= '0;
      cand_x        <= '0;
      cand_y        <= '0;
      x_plus        <= '0;
      y_plus        <= '0;
      x_minus       <= '0;
      y_minus       <= '0;
      plus_active   <= 1'b0;
      minus_active  <= 1'b0;
      bonus_pulse   <= 1'b0;
      penalty_pulse <= 1'b0;
      try_cnt       <= '0;
      timer         <= '0;
      pend_m        <= 1'b0;
    end else begin
      bonus_pulse   <= take_plus;
      penalty_pulse <= take_minus;

      if (state == S_PICK && in_range) begin
        cand_x    <= cx;
        cand_y    <= cy;
        maze_addr <= 10'(cy) * 10'(GRID_W) + 10'(cx);
      end

      if (state == S_IDLE || (state == S_BACKOFF && frame_tick) || (state == S_CHECK && accept))
        try_cnt <= '0;
      else if (reject)
        try_cnt <= try_cnt + TCW'(1);

      if (state == S_IDLE || state == S_ARMED)
        pend_m <= 1'b0;
      else if (state == S_CHECK && accept)
        pend_m <= 1'b1;

      if (state == S_CHECK && accept) begin
        if (pend_m) begin
          x_minus <= cand_x;
          y_minus <= cand_y;
        end else begin
          x_plus  <= cand_x;
          y_plus  <= cand_y;
        end
      end

      // leaving ARMED for any reason retires whatever is still on the board
      if (state == S_ARMED) begin
        if (state_nxt != S_ARMED) begin
          plus_active  <= 1'b0;
          minus_active <= 1'b0;
        end else begin
          if (take_plus)  plus_active  <= 1'b0;
          if (take_minus) minus_active <= 1'b0;
        end
      end else begin
        plus_active  <= (state == S_DRAW) && draw_done && enable;
        minus_active <= (state == S_DRAW) && draw_done && enable;
      end

      if (state == S_DRAW && draw_done)
        timer <= TMW'(RESPAWN_FRAMES);
      else if (state == S_ARMED && frame_tick && timer != '0)
        timer <= timer - TMW'(1);
    end
  end

endmodule
